// File: rtl/alu_control_sequencer.sv
// alu_control_sequencer: Moore control sequencer for the single-bus datapath.
// Steps T0..T7 per instruction (fetch T0-T2, execute T3+), HALT on halt/stop.
// Optional build macro MEM_WAIT_EN adds mem_ready and stretches memory steps.
module alu_control_sequencer #(
   parameter int unsigned IR_WIDTH = 32,
   parameter int unsigned OP_WIDTH = 5,
   parameter int unsigned LINK_REG = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IR_WIDTH-1:0] ir,
   input  logic                con_ff,
   input  logic                stop,
`ifdef MEM_WAIT_EN
   input  logic                mem_ready,
`endif
   output logic [OP_WIDTH-1:0] alu_control,
   output logic                inc_pc,
   output logic                pc_out,
   output logic                pc_in,
   output logic                mar_in,
   output logic                mdr_in,
   output logic                mdr_out,
   output logic                ir_in,
   output logic                y_in,
   output logic                z_in,
   output logic                z_low_out,
   output logic                z_high_out,
   output logic                hi_in,
   output logic                lo_in,
   output logic                hi_out,
   output logic                lo_out,
   output logic                gra,
   output logic                grb,
   output logic                grc,
   output logic                r_in,
   output logic                r_out,
   output logic                ba_out,
   output logic                c_out,
   output logic                con_in,
   output logic                link_sel,
   output logic                read,
   output logic                write,
   output logic                in_port_out,
   output logic                out_port_in,
   output logic                run,
   output logic [3:0]          step
);

   typedef enum logic [3:0] {
      T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
      T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
      HALT = 4'd15
   } step_e;

   localparam logic [OP_WIDTH-1:0] OP_LD   = OP_WIDTH'(0);
   localparam logic [OP_WIDTH-1:0] OP_LDI  = OP_WIDTH'(1);
   localparam logic [OP_WIDTH-1:0] OP_ST   = OP_WIDTH'(2);
   localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(3);
   localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(5);
   localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(6);
   localparam logic [OP_WIDTH-1:0] OP_ROL  = OP_WIDTH'(11);
   localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(12);
   localparam logic [OP_WIDTH-1:0] OP_ANDI = OP_WIDTH'(13);
   localparam logic [OP_WIDTH-1:0] OP_ORI  = OP_WIDTH'(14);
   localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(15);
   localparam logic [OP_WIDTH-1:0] OP_DIV  = OP_WIDTH'(16);
   localparam logic [OP_WIDTH-1:0] OP_NEG  = OP_WIDTH'(17);
   localparam logic [OP_WIDTH-1:0] OP_NOT  = OP_WIDTH'(18);
   localparam logic [OP_WIDTH-1:0] OP_BR   = OP_WIDTH'(19);
   localparam logic [OP_WIDTH-1:0] OP_JR   = OP_WIDTH'(20);
   localparam logic [OP_WIDTH-1:0] OP_JAL  = OP_WIDTH'(21);
   localparam logic [OP_WIDTH-1:0] OP_IN   = OP_WIDTH'(22);
   localparam logic [OP_WIDTH-1:0] OP_OUT  = OP_WIDTH'(23);
   localparam logic [OP_WIDTH-1:0] OP_MFHI = OP_WIDTH'(24);
   localparam logic [OP_WIDTH-1:0] OP_MFLO = OP_WIDTH'(25);
   localparam logic [OP_WIDTH-1:0] OP_NOP  = OP_WIDTH'(26);
   localparam logic [OP_WIDTH-1:0] OP_HALT = OP_WIDTH'(27);

   // Link register index must fit the register-select field.
   if (LINK_REG >= 16) begin : g_link_reg_check
      $error("LINK_REG out of range");
   end

   step_e               step_q, step_d;
   logic [OP_WIDTH-1:0] op_q, op_d;
   logic [OP_WIDTH-1:0] op_ir;
   logic                mem_ok;
   logic                unused_inputs;

   // Branch outcome is resolved by the ALU; only the opcode field of ir is used here.
   assign unused_inputs = ^{con_ff, ir[IR_WIDTH-OP_WIDTH-1:0]};
   assign op_ir = ir[IR_WIDTH-1 -: OP_WIDTH];
`ifdef MEM_WAIT_EN
   assign mem_ok = mem_ready;
`else
   assign mem_ok = 1'b1;
`endif

   // Final execute step of each opcode class.
   function automatic step_e last_step(input logic [OP_WIDTH-1:0] op);
      case (op) inside
         [OP_ADD:OP_ORI], OP_LDI:  return T5;
         OP_MUL, OP_DIV, OP_BR:    return T6;
         OP_NEG, OP_NOT, OP_JAL:   return T4;
         OP_LD, OP_ST:             return T7;
         default:                  return T3;
      endcase
   endfunction

   // State register: step and the opcode latched at the end of T2.
   always_ff @(posedge clk) begin
      if (reset) begin
         step_q <= T0;
         op_q   <= '0;
      end else begin
         step_q <= step_d;
         op_q   <= op_d;
      end
   end

   // Next-state: advance one step per clock, memory steps may hold, stop diverts T0 entry.
   always_comb begin
      logic to_t0;
      step_d = step_q;
      op_d   = op_q;
      to_t0  = 1'b0;
      case (step_q)
         T0: step_d = T1;
         T1: if (mem_ok) step_d = T2;
         T2: begin
            op_d = op_ir;
            if (op_ir == OP_HALT)     step_d = HALT;
            else if (op_ir >= OP_NOP) to_t0  = 1'b1;
            else                      step_d = T3;
         end
         T3, T4, T5, T6, T7: begin
            if (((op_q == OP_LD && step_q == T6) || (op_q == OP_ST && step_q == T7)) && !mem_ok)
               step_d = step_q;
            else if (step_q == last_step(op_q))
               to_t0 = 1'b1;
            else
               step_d = step_e'(step_q + 4'd1);
         end
         HALT:    step_d = HALT;
         default: to_t0  = 1'b1;
      endcase
      if (to_t0) step_d = stop ? HALT : T0;
   end

   // Output decode from the state register; everything forced low during reset.
   always_comb begin
      alu_control = '0;
      {inc_pc, pc_out, pc_in, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in} = '0;
      {z_low_out, z_high_out, hi_in, lo_in, hi_out, lo_out} = '0;
      {gra, grb, grc, r_in, r_out, ba_out, c_out, con_in, link_sel} = '0;
      {read, write, in_port_out, out_port_in, run} = '0;
      step = 4'd0;
      if (!reset) begin
         step = 4'(step_q);
         run  = (step_q != HALT);
         case (step_q)
            T0: {pc_out, mar_in, inc_pc, z_in} = '1;
            T1: {z_low_out, pc_in, read, mdr_in} = '1;
            T2: {mdr_out, ir_in} = '1;
            T3: case (op_q) inside
               [OP_ADD:OP_ORI]:      {grb, r_out, y_in} = '1;
               OP_MUL, OP_DIV:       {gra, r_out, y_in} = '1;
               OP_NEG, OP_NOT: begin {grb, r_out, z_in} = '1; alu_control = op_q; end
               OP_LD, OP_LDI, OP_ST: {grb, ba_out, y_in} = '1;
               OP_BR:                {gra, r_out, con_in} = '1;
               OP_JR:                {gra, r_out, pc_in} = '1;
               OP_JAL:               {pc_out, r_in, link_sel} = '1;
               OP_MFHI:              {hi_out, gra, r_in} = '1;
               OP_MFLO:              {lo_out, gra, r_in} = '1;
               OP_IN:                {in_port_out, gra, r_in} = '1;
               OP_OUT:               {gra, r_out, out_port_in} = '1;
               default: ;
            endcase
            T4: case (op_q) inside
               [OP_ADD:OP_ROL]: begin {grc, r_out, z_in} = '1; alu_control = op_q; end
               OP_ADDI:         begin {c_out, z_in} = '1; alu_control = OP_ADD; end
               OP_ANDI:         begin {c_out, z_in} = '1; alu_control = OP_AND; end
               OP_ORI:          begin {c_out, z_in} = '1; alu_control = OP_OR; end
               OP_MUL, OP_DIV:  begin {grb, r_out, z_in} = '1; alu_control = op_q; end
               OP_NEG, OP_NOT:        {z_low_out, gra, r_in} = '1;
               OP_LD, OP_LDI, OP_ST: begin {c_out, z_in} = '1; alu_control = OP_ADD; end
               OP_BR:                 {pc_out, y_in} = '1;
               OP_JAL:                {gra, r_out, pc_in} = '1;
               default: ;
            endcase
            T5: case (op_q) inside
               [OP_ADD:OP_ORI], OP_LDI: {z_low_out, gra, r_in} = '1;
               OP_MUL, OP_DIV:          {z_low_out, lo_in} = '1;
               OP_LD, OP_ST:            {z_low_out, mar_in} = '1;
               OP_BR: begin {c_out, z_in} = '1; alu_control = OP_BR; end
               default: ;
            endcase
            T6: case (op_q) inside
               OP_MUL, OP_DIV: {z_high_out, hi_in} = '1;
               OP_LD:          {read, mdr_in} = '1;
               OP_ST:          {gra, r_out, mdr_in} = '1;
               OP_BR:          {z_low_out, pc_in} = '1;
               default: ;
            endcase
            T7: case (op_q)
               OP_LD:   {mdr_out, gra, r_in} = '1;
               OP_ST:   write = 1'b1;
               default: ;
            endcase
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer: per-step strobe/alu/step checks.
module tb_alu_control_sequencer;

   logic        clk, reset, con_ff, stop;
   logic [31:0] ir;
`ifdef MEM_WAIT_EN
   logic        mem_ready;
`endif
   logic [4:0]  alu_control;
   logic [3:0]  step;
   logic inc_pc, pc_out, pc_in, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in;
   logic z_low_out, z_high_out, hi_in, lo_in, hi_out, lo_out;
   logic gra, grb, grc, r_in, r_out, ba_out, c_out, con_in, link_sel;
   logic read, write, in_port_out, out_port_in, run;
   logic [28:0] obs;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [28:0] PC_OUT = 29'h1 << 28, PC_IN = 29'h1 << 27, MAR_IN = 29'h1 << 26;
   localparam logic [28:0] MDR_IN = 29'h1 << 25, MDR_OUT = 29'h1 << 24, IR_IN = 29'h1 << 23;
   localparam logic [28:0] Y_IN = 29'h1 << 22, Z_IN = 29'h1 << 21, Z_LOW_OUT = 29'h1 << 20;
   localparam logic [28:0] Z_HIGH_OUT = 29'h1 << 19, HI_IN = 29'h1 << 18, LO_IN = 29'h1 << 17;
   localparam logic [28:0] HI_OUT = 29'h1 << 16, LO_OUT = 29'h1 << 15, GRA = 29'h1 << 14;
   localparam logic [28:0] GRB = 29'h1 << 13, GRC = 29'h1 << 12, R_IN = 29'h1 << 11;
   localparam logic [28:0] R_OUT = 29'h1 << 10, BA_OUT = 29'h1 << 9, C_OUT = 29'h1 << 8;
   localparam logic [28:0] CON_IN = 29'h1 << 7, LINK_SEL = 29'h1 << 6, READ = 29'h1 << 5;
   localparam logic [28:0] WRITE = 29'h1 << 4, IN_PORT_OUT = 29'h1 << 3, OUT_PORT_IN = 29'h1 << 2;
   localparam logic [28:0] INC_PC = 29'h1 << 1, RUN = 29'h1;

   assign obs = {pc_out, pc_in, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, z_low_out,
                 z_high_out, hi_in, lo_in, hi_out, lo_out, gra, grb, grc, r_in, r_out,
                 ba_out, c_out, con_in, link_sel, read, write, in_port_out, out_port_in,
                 inc_pc, run};

   alu_control_sequencer dut (
      .clk(clk), .reset(reset), .ir(ir), .con_ff(con_ff), .stop(stop),
`ifdef MEM_WAIT_EN
      .mem_ready(mem_ready),
`endif
      .alu_control(alu_control), .inc_pc(inc_pc), .pc_out(pc_out), .pc_in(pc_in),
      .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in),
      .z_in(z_in), .z_low_out(z_low_out), .z_high_out(z_high_out), .hi_in(hi_in),
      .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out), .gra(gra), .grb(grb), .grc(grc),
      .r_in(r_in), .r_out(r_out), .ba_out(ba_out), .c_out(c_out), .con_in(con_in),
      .link_sel(link_sel), .read(read), .write(write), .in_port_out(in_port_out),
      .out_port_in(out_port_in), .run(run), .step(step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check the current step's outputs, then advance one clock.
   task automatic step_chk(input string tag, input int s, input logic [4:0] alu, input logic [28:0] strb);
      logic [28:0] exp_strb;
      exp_strb = (s != 15) ? (strb | RUN) : strb;
      check($sformatf("%s T%0d step", tag, s), 32'(step), 32'(s));
      check($sformatf("%s T%0d alu", tag, s), 32'(alu_control), 32'(alu));
      check($sformatf("%s T%0d strb", tag, s), 32'(obs), 32'(exp_strb));
      tick();
   endtask

   task automatic fetch(input string tag, input logic [4:0] op);
      ir = {op, 27'h0123456};
      step_chk(tag, 0, 5'd0, PC_OUT | MAR_IN | INC_PC | Z_IN);
      step_chk(tag, 1, 5'd0, Z_LOW_OUT | PC_IN | READ | MDR_IN);
      step_chk(tag, 2, 5'd0, MDR_OUT | IR_IN);
   endtask

   task automatic reset_pulse(input string tag);
      reset = 1'b1;
      tick();
      check({tag, " rst strb"}, 32'(obs), 32'h0);
      check({tag, " rst step"}, 32'(step), 32'h0);
      reset = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1; stop = 1'b0; con_ff = 1'b0; ir = 32'h0;
`ifdef MEM_WAIT_EN
      mem_ready = 1'b1;
`endif
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("reset%0d strb", i), 32'(obs), 32'h0);
         check($sformatf("reset%0d alu", i), 32'(alu_control), 32'h0);
         check($sformatf("reset%0d step", i), 32'(step), 32'h0);
      end
      reset = 1'b0;
      #1;

      // add: 6 cycles, back to T0
      fetch("add", 5'b00011);
      step_chk("add", 3, 5'd0, GRB | R_OUT | Y_IN);
      step_chk("add", 4, 5'b00011, GRC | R_OUT | Z_IN);
      step_chk("add", 5, 5'd0, Z_LOW_OUT | GRA | R_IN);

      // mul: LO then HI capture
      fetch("mul", 5'b01111);
      step_chk("mul", 3, 5'd0, GRA | R_OUT | Y_IN);
      step_chk("mul", 4, 5'b01111, GRB | R_OUT | Z_IN);
      step_chk("mul", 5, 5'd0, Z_LOW_OUT | LO_IN);
      step_chk("mul", 6, 5'd0, Z_HIGH_OUT | HI_IN);

      // ld: address calc then memory read
      fetch("ld", 5'b00000);
      step_chk("ld", 3, 5'd0, GRB | BA_OUT | Y_IN);
      step_chk("ld", 4, 5'b00011, C_OUT | Z_IN);
      step_chk("ld", 5, 5'd0, Z_LOW_OUT | MAR_IN);
      step_chk("ld", 6, 5'd0, READ | MDR_IN);
      step_chk("ld", 7, 5'd0, MDR_OUT | GRA | R_IN);

      // ldi: ends after T5
      fetch("ldi", 5'b00001);
      step_chk("ldi", 3, 5'd0, GRB | BA_OUT | Y_IN);
      step_chk("ldi", 4, 5'b00011, C_OUT | Z_IN);
      step_chk("ldi", 5, 5'd0, Z_LOW_OUT | GRA | R_IN);

      // andi: immediate path maps to AND code
      fetch("andi", 5'b01101);
      step_chk("andi", 3, 5'd0, GRB | R_OUT | Y_IN);
      step_chk("andi", 4, 5'b00101, C_OUT | Z_IN);
      step_chk("andi", 5, 5'd0, Z_LOW_OUT | GRA | R_IN);

      // jal: link write then jump
      fetch("jal", 5'b10101);
      step_chk("jal", 3, 5'd0, PC_OUT | R_IN | LINK_SEL);
      step_chk("jal", 4, 5'd0, GRA | R_OUT | PC_IN);

      // st: write in T7
      fetch("st", 5'b00010);
      step_chk("st", 3, 5'd0, GRB | BA_OUT | Y_IN);
      step_chk("st", 4, 5'b00011, C_OUT | Z_IN);
      step_chk("st", 5, 5'd0, Z_LOW_OUT | MAR_IN);
      step_chk("st", 6, 5'd0, GRA | R_OUT | MDR_IN);
      step_chk("st", 7, 5'd0, WRITE);

      // nop then undefined opcode: straight back to T0
      fetch("nop", 5'b11010);
      fetch("undef", 5'b11110);

`ifdef MEM_WAIT_EN
      // T1 stalls while memory is not ready
      ir = {5'b11010, 27'h0};
      mem_ready = 1'b0;
      step_chk("mw", 0, 5'd0, PC_OUT | MAR_IN | INC_PC | Z_IN);
      for (int i = 0; i < 4; i++) step_chk("mw wait", 1, 5'd0, Z_LOW_OUT | PC_IN | READ | MDR_IN);
      mem_ready = 1'b1;
      step_chk("mw rdy", 1, 5'd0, Z_LOW_OUT | PC_IN | READ | MDR_IN);
      step_chk("mw", 2, 5'd0, MDR_OUT | IR_IN);
`endif

      // stop raised mid-add: add completes, then HALT
      fetch("stop", 5'b00011);
      step_chk("stop", 3, 5'd0, GRB | R_OUT | Y_IN);
      stop = 1'b1;
      step_chk("stop", 4, 5'b00011, GRC | R_OUT | Z_IN);
      step_chk("stop", 5, 5'd0, Z_LOW_OUT | GRA | R_IN);
      stop = 1'b0;
      for (int i = 0; i < 3; i++) step_chk("stop halt", 15, 5'd0, 29'h0);
      reset_pulse("stop");

      // halt instruction: parks in HALT until reset
      fetch("halt", 5'b11011);
      for (int i = 0; i < 4; i++) step_chk("halt", 15, 5'd0, 29'h0);
      reset_pulse("halt");
      fetch("post", 5'b10110);
      step_chk("in", 3, 5'd0, IN_PORT_OUT | GRA | R_IN);
      step_chk("post", 0, 5'd0, PC_OUT | MAR_IN | INC_PC | Z_IN);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
